// File: rtl/mips20_pkg.sv
// Shared types and constants for the 20-bit MIPS-style front end.
package mips20_pkg;

    localparam int XLEN = 20;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t instruction;
        word_t pc_plus1;
    } fetch_entry_t;

    localparam word_t DEFAULT_RESET_PC = 20'h00000;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched instructions with push/pop/flush and occupancy count.
module fetch_fifo
    import mips20_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: credit-limited memory requests, in-order tag queue, redirect drop.
// Build option PC_FETCH_PERF_CNT_EN enables the saturating bubble counter.
module pc_fetch
    import mips20_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            fetch_valid,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] result_increment_pc,
    output logic [15:0]     bubble_count
);

    word_t        pc;
    logic [1:0]   outstanding;
    logic [1:0]   drop_cnt;
    word_t        tag_q [2];
    logic         tag_wr;
    logic         tag_rd;
    logic [1:0]   fifo_count;
    logic [2:0]   occupancy;
    logic         accept;
    logic         push;
    logic         pop;
    fetch_entry_t push_data;
    fetch_entry_t head;

    // Outstanding includes responses still to be dropped, so they hold credit too.
    assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req  = !rst && !redirect_valid && (occupancy < 3'(FIFO_DEPTH));
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;

    assign push      = imem_rvalid && !redirect_valid && (drop_cnt == 2'd0);
    assign pop       = fetch_valid && !stall;
    assign push_data = '{instruction: imem_rdata, pc_plus1: tag_q[tag_rd]};

    assign fetch_valid         = (fifo_count != 2'd0);
    assign instruction         = head.instruction;
    assign result_increment_pc = head.pc_plus1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (accept) begin
            pc <= pc + 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= 2'd0;
        end else begin
            unique case ({accept, imem_rvalid})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 2'd0;
        end else if (redirect_valid) begin
            drop_cnt <= outstanding - {1'b0, imem_rvalid};
        end else if (imem_rvalid && (drop_cnt != 2'd0)) begin
            drop_cnt <= drop_cnt - 2'd1;
        end
    end

    // Tags pop on every response, dropped or not, so they stay aligned with the memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr <= 1'b0;
            tag_rd <= 1'b0;
        end else begin
            if (accept) begin
                tag_q[tag_wr] <= pc + 20'd1;
                tag_wr        <= ~tag_wr;
            end
            if (imem_rvalid) begin
                tag_rd <= ~tag_rd;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

`ifdef PC_FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_count <= 16'd0;
        end else if (!fetch_valid && (bubble_count != 16'hFFFF)) begin
            bubble_count <= bubble_count + 16'd1;
        end
    end
`else
    assign bubble_count = 16'd0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with an in-order, fixed-latency memory responder.
module tb_pc_fetch;
    import mips20_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [19:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [19:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [19:0] imem_rdata = 20'h0;
    logic        fetch_valid;
    logic [19:0] instruction;
    logic [19:0] result_increment_pc;
    logic [15:0] bubble_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int exp_bubbles = 0;

    typedef struct {
        int          due;
        logic [19:0] addr;
    } rsp_t;
    rsp_t rq[$];

    pc_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .stall               (stall),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_gnt            (imem_gnt),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .fetch_valid         (fetch_valid),
        .instruction         (instruction),
        .result_increment_pc (result_increment_pc),
        .bubble_count        (bubble_count)
    );

    always #5 clk = ~clk;

    // Mid-cycle: record accepted requests and count bubble cycles.
    always @(negedge clk) begin
        if (!rst && imem_req && imem_gnt)
            rq.push_back('{due: cyc + lat, addr: imem_addr});
        if (rst) exp_bubbles = 0;
        else if (!fetch_valid) exp_bubbles++;
    end

    // Responses come back in order, lat cycles after the grant cycle.
    always @(posedge clk) begin
        cyc++;
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 20'h0;
        if (rst) begin
            rq.delete();
        end else if (rq.size() > 0 && rq[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = rq[0].addr + 20'h00100;
            void'(rq.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        redirect_valid = 1'b0;
        stall = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] exp_bub();
`ifdef PC_FETCH_PERF_CNT_EN
        return (exp_bubbles > 65535) ? 32'd65535 : 32'(exp_bubbles);
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 20'h0;
        stall = 1'b0; imem_gnt = 1'b1; lat = 1;
        repeat (3) step();
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_fv", fetch_valid, 0);
        chk("rst_bubble", bubble_count, 0);
        chk("rst_addr", imem_addr, 20'h00000);

        // Streaming with 1-cycle memory, then a long stall.
        step(); rst = 1'b0; #1;
        chk("c0_req", imem_req, 1);
        chk("c0_addr", imem_addr, 20'h00000);
        chk("c0_fv", fetch_valid, 0);
        step(); #1;
        chk("c1_req", imem_req, 1);
        chk("c1_addr", imem_addr, 20'h00001);
        step(); stall = 1'b1; #1;
        chk("first_fv", fetch_valid, 1);
        chk("first_instr", instruction, 20'h00100);
        chk("first_pc1", result_increment_pc, 20'h00001);
        chk("c2_req", imem_req, 0);
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            chk("stall_req", imem_req, 0);
            chk("stall_head", instruction, 20'h00100);
        end
        step(); stall = 1'b0; #1;
        chk("rel0_instr", instruction, 20'h00100);
        chk("rel0_pc1", result_increment_pc, 20'h00001);
        chk("rel0_req", imem_req, 0);
        step(); #1;
        chk("rel1_fv", fetch_valid, 1);
        chk("rel1_instr", instruction, 20'h00101);
        chk("rel1_pc1", result_increment_pc, 20'h00002);
        chk("rel1_req", imem_req, 1);
        chk("rel1_addr", imem_addr, 20'h00002);
        step(); #1;
        chk("rel2_fv", fetch_valid, 0);
        chk("rel2_addr", imem_addr, 20'h00003);
        step(); #1;
        chk("rel3_fv", fetch_valid, 1);
        chk("rel3_instr", instruction, 20'h00102);
        chk("rel3_pc1", result_increment_pc, 20'h00003);
        chk("bubbles_a", bubble_count, exp_bub());

        // Redirect with two responses in flight, 3-cycle memory.
        lat = 3;
        do_reset(); #1;
        chk("d0_req", imem_req, 1);
        chk("d0_addr", imem_addr, 20'h00000);
        step(); #1;
        chk("d1_addr", imem_addr, 20'h00001);
        step(); redirect_valid = 1'b1; redirect_pc = 20'h0ABCD; #1;
        chk("d2_redir_req", imem_req, 0);
        step(); redirect_valid = 1'b0; #1;
        chk("d3_req_held", imem_req, 0);
        chk("d3_addr", imem_addr, 20'h0ABCD);
        chk("d3_fv", fetch_valid, 0);
        step(); #1;
        chk("d4_req", imem_req, 1);
        chk("d4_addr", imem_addr, 20'h0ABCD);
        chk("d4_fv", fetch_valid, 0);
        step(); #1;
        chk("d5_addr", imem_addr, 20'h0ABCE);
        step(); step(); #1;
        chk("d7_fv", fetch_valid, 0);
        step(); #1;
        chk("d8_fv", fetch_valid, 1);
        chk("d8_instr", instruction, 20'h0ACCD);
        chk("d8_pc1", result_increment_pc, 20'h0ABCE);

        // Redirect coinciding with a response and a pop, then back-to-back redirects and PC wrap.
        lat = 2;
        do_reset(); #1;
        chk("e0_addr", imem_addr, 20'h00000);
        step(); step(); step(); #1;
        chk("e3_fv", fetch_valid, 1);
        chk("e3_instr", instruction, 20'h00100);
        step(); #1;
        chk("e4_instr", instruction, 20'h00101);
        chk("e4_req", imem_req, 1);
        chk("e4_addr", imem_addr, 20'h00002);
        step(); step(); step(); redirect_valid = 1'b1; redirect_pc = 20'h55555; #1;
        chk("e7_instr", instruction, 20'h00102);
        chk("e7_pc1", result_increment_pc, 20'h00003);
        chk("e7_req", imem_req, 0);
        step(); redirect_valid = 1'b0; #1;
        chk("e8_fv", fetch_valid, 0);
        chk("e8_req", imem_req, 1);
        chk("e8_addr", imem_addr, 20'h55555);
        step(); #1;
        chk("e9_addr", imem_addr, 20'h55556);
        step(); #1;
        chk("e10_fv", fetch_valid, 0);
        step(); redirect_valid = 1'b1; redirect_pc = 20'h11111; #1;
        chk("e11_fv", fetch_valid, 1);
        chk("e11_instr", instruction, 20'h55655);
        chk("e11_pc1", result_increment_pc, 20'h55556);
        step(); redirect_pc = 20'hFFFFF; #1;
        chk("e12_fv", fetch_valid, 0);
        chk("e12_req", imem_req, 0);
        step(); redirect_valid = 1'b0; #1;
        chk("e13_req", imem_req, 1);
        chk("e13_addr", imem_addr, 20'hFFFFF);
        step(); #1;
        chk("e14_req", imem_req, 1);
        chk("e14_wrap_addr", imem_addr, 20'h00000);
        step(); #1;
        chk("e15_fv", fetch_valid, 0);
        step(); #1;
        chk("e16_fv", fetch_valid, 1);
        chk("e16_instr", instruction, 20'h000FF);
        chk("e16_wrap_pc1", result_increment_pc, 20'h00000);
        chk("bubbles_b", bubble_count, exp_bub());

        // No grant: request and address must hold.
        lat = 1;
        imem_gnt = 1'b0;
        do_reset(); #1;
        for (int i = 0; i < 5; i++) begin
            chk("nogrant_req", imem_req, 1);
            chk("nogrant_addr", imem_addr, 20'h00000);
            step(); #1;
        end
        chk("nogrant_fv", fetch_valid, 0);
        chk("bubbles_c", bubble_count, exp_bub());
`ifdef PC_FETCH_PERF_CNT_EN
        repeat (70000) step();
        #1;
        chk("bubble_sat", bubble_count, 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
